// File: rtl/key_pulse_pkg.sv
// Shared definitions for the key pulse generator: FSM state encodings and
// the counter-width helper used to size the debounce and repeat counters.
package key_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced key with single-cycle press strobe and optional auto-repeat.
//   state       | meaning
//   IDLE        | key released, waiting for a high sample
//   PRESS_CHK   | counting stable high samples before accepting the press
//   HELD        | press accepted, level high, auto-repeat timer running
//   RELEASE_CHK | counting stable low samples; repeat timer frozen
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse,
  output logic level
);

  import key_pulse_pkg::*;

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW      = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int RW      = cnt_width(REP_MAX - 1);

  localparam logic [DW-1:0] DB_TC     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_TC  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD - 1);

  logic            sync;
  key_state_t      state;
  logic [DW-1:0]   db_cnt;
  logic [RW-1:0]   rep_cnt;
  logic            rep_run;
  logic [RW-1:0]   rep_tc;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync)
  );

  // Until the first repeat fires the timer runs to the delay, then to the period.
  always_comb begin
    rep_tc = rep_run ? PERIOD_TC : DELAY_TC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      db_cnt  <= '0;
      rep_cnt <= '0;
      rep_run <= 1'b0;
      pulse   <= 1'b0;
      level   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!sync) begin
            state <= IDLE;
          end else if (db_cnt == DB_TC) begin
            state   <= HELD;
            pulse   <= 1'b1;
            level   <= 1'b1;
            rep_cnt <= '0;
            rep_run <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
          end
          // At terminal count the timer waits one cycle if the previous
          // cycle already pulsed, so strobes never run back to back.
          if (!repeat_en) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
          end else if (rep_cnt == rep_tc) begin
            if (!pulse) begin
              pulse   <= 1'b1;
              rep_cnt <= '0;
              rep_run <= 1'b1;
            end
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        RELEASE_CHK: begin
          if (sync) begin
            state <= HELD;
          end else if (db_cnt == DB_TC) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen: main config (4,20,8) and minimum config (1,3,1).
module tb_key_pulse_gen;

  logic clk;
  logic reset, btn, ren;
  logic rst2, btn2, ren2;
  logic pulse, level;
  logic pulse2, level2;

  int n_tot = 0;
  int n_bad = 0;
  int ecnt  = 0;
  int pq[$];
  logic prev_p  = 1'b0;
  logic prev_p2 = 1'b0;

  key_pulse_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn),
    .repeat_en (ren),
    .pulse     (pulse),
    .level     (level)
  );

  key_pulse_gen #(.DEBOUNCE_CYCLES(1), .REPEAT_DELAY(3), .REPEAT_PERIOD(1)) dut2 (
    .clk       (clk),
    .reset     (rst2),
    .btn_in    (btn2),
    .repeat_en (ren2),
    .pulse     (pulse2),
    .level     (level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pulse) begin
      chk("no_back_to_back", 32'(prev_p), 0);
      pq.push_back(ecnt);
    end
    prev_p = pulse;
  end

  always @(negedge clk) begin
    if (pulse2) chk("no_back_to_back_min", 32'(prev_p2), 0);
    prev_p2 = pulse2;
  end

  function automatic int pq_at(input int k);
    if (k < pq.size()) return pq[k];
    return -1000000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    btn   = 1'b0;
    ren   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    pq.delete();
  endtask

  int t0, t1, pp;
  int rep_exp[6]  = '{0, 20, 28, 36, 44, 52};
  int glit_exp[4] = '{0, 22, 30, 38};
  logic [4:0] bv;

  initial begin
    reset = 1'b1; btn = 1'b0; ren = 1'b0;
    rst2  = 1'b1; btn2 = 1'b0; ren2 = 1'b0;
    #2;
    reset = 1'b0;
    rst2  = 1'b0;
    #1;
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_state", 32'(dut.state), 0);
    chk("rst_sync",  32'(dut.sync), 0);

    // clean press, repeat disabled
    do_reset();
    t0 = ecnt;
    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("clean_pulse_e%0d", i), 32'(pulse), 32'(i == 7));
      chk($sformatf("clean_level_e%0d", i), 32'(level), 32'(i >= 7));
    end
    repeat (40) @(negedge clk);
    chk("clean_count", pq.size(), 1);
    chk("clean_edge", pq_at(0) - t0, 7);

    // bounce 1,0,1,1,0 then stable high from sample 6
    do_reset();
    bv = 5'b01101;
    t0 = ecnt;
    for (int i = 1; i <= 16; i++) begin
      btn = (i <= 5) ? bv[i-1] : 1'b1;
      @(negedge clk);
      chk($sformatf("bounce_pulse_e%0d", i), 32'(pulse), 32'(i == 12));
    end
    chk("bounce_count", pq.size(), 1);

    // auto-repeat, then repeat_en off/on restarts the full delay
    do_reset();
    ren = 1'b1;
    t0 = ecnt;
    btn = 1'b1;
    pp = t0 + 7;
    repeat (65) @(negedge clk);
    chk("rep_count", pq.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("rep_edge%0d", k), pq_at(k) - pp, rep_exp[k]);
    ren = 1'b0;
    repeat (4) @(negedge clk);
    ren = 1'b1;
    repeat (26) @(negedge clk);
    chk("rep_restart_count", pq.size(), 7);
    chk("rep_restart_edge", pq_at(6) - pp, 82);

    // release glitch of two samples, then full release
    do_reset();
    ren = 1'b1;
    t0 = ecnt;
    btn = 1'b1;
    pp = t0 + 7;
    repeat (12) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    for (int k = 8; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("glitch_level_p%0d", k), 32'(level), 1);
      chk($sformatf("glitch_pulse_p%0d", k), 32'(pulse), 0);
    end
    repeat (28) @(negedge clk);
    chk("glitch_count", pq.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("glitch_edge%0d", k), pq_at(k) - pp, glit_exp[k]);
    btn = 1'b0;
    for (int k = 41; k <= 50; k++) begin
      @(negedge clk);
      chk($sformatf("release_level_p%0d", k), 32'(level), 32'(k < 47));
      chk($sformatf("release_pulse_p%0d", k), 32'(pulse), 0);
    end
    chk("release_count", pq.size(), 4);

    // asynchronous reset in the middle of the press debounce
    do_reset();
    t0 = ecnt;
    btn = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_db_cnt", 32'(dut.db_cnt), 2);
    chk("mid_state", 32'(dut.state), 1);
    reset = 1'b0;
    #1;
    chk("abort_pulse", 32'(pulse), 0);
    chk("abort_level", 32'(level), 0);
    chk("abort_state", 32'(dut.state), 0);
    chk("abort_db_cnt", 32'(dut.db_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    pq.delete();
    t1 = ecnt;
    repeat (12) @(negedge clk);
    chk("after_rst_count", pq.size(), 1);
    chk("after_rst_edge", pq_at(0) - t1, 7);

    // minimum configuration: press at edge 4, repeats alternate with low cycles
    @(negedge clk);
    rst2 = 1'b1;
    ren2 = 1'b1;
    @(negedge clk);
    btn2 = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk($sformatf("min_pulse_e%0d", i), 32'(pulse2),
          32'((i == 4) || (i == 7) || (i >= 9 && (i % 2) == 1)));
    end
    chk("min_level", 32'(level2), 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
